// File: rtl/branch_sequencer_pkg.sv
// Shared constants and state encoding for the branch sequencer.
// Opcode, ALU op and operand-select codes as seen on the datapath.
package branch_sequencer_pkg;

    localparam logic [5:0] OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_BLEZ   = 6'd6;
    localparam logic [5:0] OP_BGTZ   = 6'd7;

    localparam logic [2:0] ALU_IDLE  = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_ZERO   = 2'b10;
    localparam logic [1:0] SRC_B_OFFSET = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TARGET,
        S_COMPARE,
        S_RESOLVE,
        S_FINISH
    } state_t;

    function automatic logic is_supported(logic [5:0] op, logic [4:0] rt);
        return (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BLEZ) || (op == OP_BGTZ) ||
               ((op == OP_REGIMM) && (rt[4:1] == 4'd0));
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from the latched opcode and ALU flags.
// rt_lsb distinguishes bgez (1) from bltz (0) under OP_REGIMM.
module branch_cond
    import branch_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       rt_lsb,
    input  logic       igual,
    input  logic       maior,
    input  logic       menor,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:    taken = igual;
            OP_BNE:    taken = !igual;
            OP_BLEZ:   taken = !maior;
            OP_BGTZ:   taken = maior;
            OP_REGIMM: taken = rt_lsb ? !menor : menor;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multicycle conditional-branch sequencer: target, compare, resolve, finish.
// Unsupported branches pass through RESOLVE with the PC write suppressed.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [4:0]       rt,
    input  logic             igual,
    input  logic             maior,
    input  logic             menor,
    input  logic             clr_cnt,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             aluout_load,
    output logic             pc_src_aluout,
    output logic             pc_write,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt
);

    state_t state_q, state_d;

    logic [5:0]       op_q, op_d;
    logic             rt0_q, rt0_d;
    logic             ill_q, ill_d;
    logic [2:0]       flags_q, flags_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cond_taken;
    logic             take_en;

    branch_cond u_cond (
        .opcode (op_q),
        .rt_lsb (rt0_q),
        .igual  (flags_q[2]),
        .maior  (flags_q[1]),
        .menor  (flags_q[0]),
        .taken  (cond_taken)
    );

    assign take_en = (state_q == S_RESOLVE) && !ill_q && cond_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = is_supported(opcode, rt) ? S_TARGET : S_RESOLVE;
                end
            end
            S_TARGET:  state_d = S_COMPARE;
            S_COMPARE: state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_FINISH;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        rt0_d     = rt0_q;
        ill_d     = ill_q;
        flags_d   = flags_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if ((state_q == S_IDLE) && start) begin
            op_d  = opcode;
            rt0_d = rt[0];
            ill_d = !is_supported(opcode, rt);
        end
        if (state_q == S_COMPARE) begin
            flags_d = {igual, maior, menor};
        end
        // taken/illegal only change on entry to FINISH so they hold until next done
        if (state_q == S_RESOLVE) begin
            taken_d   = take_en;
            illegal_d = ill_q;
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (take_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            rt0_q     <= 1'b0;
            ill_q     <= 1'b0;
            flags_q   <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            op_q      <= op_d;
            rt0_q     <= rt0_d;
            ill_q     <= ill_d;
            flags_q   <= flags_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_IDLE;
        aluout_load   = 1'b0;
        pc_src_aluout = 1'b0;
        pc_write      = 1'b0;
        done          = 1'b0;
        busy          = (state_q != S_IDLE);
        unique case (state_q)
            S_TARGET: begin
                alu_src_b   = SRC_B_OFFSET;
                alu_op      = ALU_ADD;
                aluout_load = 1'b1;
            end
            S_COMPARE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                alu_src_b = ((op_q == OP_BEQ) || (op_q == OP_BNE)) ?
                            SRC_B_REG : SRC_B_ZERO;
            end
            S_RESOLVE: begin
                pc_src_aluout = take_en;
                pc_write      = take_en;
            end
            S_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    assign taken     = taken_q;
    assign illegal   = illegal_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized bench for branch_sequencer with a latency-based reference model.
// Directed runs pin literal expectations; a negedge process checks every cycle.
module tb_branch_sequencer;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [5:0]       opcode = '0;
    logic [4:0]       rt = '0;
    logic             igual = 1'b0;
    logic             maior = 1'b0;
    logic             menor = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             aluout_load;
    logic             pc_src_aluout;
    logic             pc_write;
    logic             busy;
    logic             done;
    logic             taken;
    logic             illegal;
    logic [CNT_W-1:0] taken_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .rt            (rt),
        .igual         (igual),
        .maior         (maior),
        .menor         (menor),
        .clr_cnt       (clr_cnt),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .aluout_load   (aluout_load),
        .pc_src_aluout (pc_src_aluout),
        .pc_write      (pc_write),
        .busy          (busy),
        .done          (done),
        .taken         (taken),
        .illegal       (illegal),
        .taken_cnt     (taken_cnt)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic m_legal_of(input logic [5:0] op, input logic [4:0] r);
        return (op == 6'd4) || (op == 6'd5) || (op == 6'd6) || (op == 6'd7) ||
               ((op == 6'd1) && (r < 5'd2));
    endfunction

    function automatic logic m_cond(input logic [5:0] op, input logic [4:0] r,
                                    input logic ig, input logic ma, input logic me);
        case (op)
            6'd4:    return ig;
            6'd5:    return !ig;
            6'd6:    return !ma;
            6'd7:    return ma;
            6'd1:    return (r == 5'd0) ? me : !me;
            default: return 1'b0;
        endcase
    endfunction

    // Model: a transaction accepted from cycle s occupies cycles s+1..s+len.
    int         cyc = 0;
    int         s = -1;
    int         len = 0;
    logic       m_legal = 1'b0;
    logic [5:0] m_op = '0;
    logic [4:0] m_rt = '0;
    logic       m_tk = 1'b0;
    logic       m_taken = 1'b0;
    logic       m_ill = 1'b0;
    int         m_cnt = 0;

    always @(posedge clk or posedge reset) begin
        int   prev;
        logic idle_prev;
        if (reset) begin
            cyc = 0; s = -1; len = 0; m_legal = 0; m_op = 0; m_rt = 0;
            m_tk = 0; m_taken = 0; m_ill = 0; m_cnt = 0;
        end else begin
            prev = cyc;
            cyc = cyc + 1;
            idle_prev = (s < 0);
            if (!idle_prev && m_legal && prev == s + 2)
                m_tk = m_cond(m_op, m_rt, igual, maior, menor);
            if (clr_cnt)
                m_cnt = 0;
            else if (!idle_prev && m_legal && prev == s + 3 && m_tk)
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (!idle_prev && cyc == s + len) begin
                m_taken = m_legal && m_tk;
                m_ill = !m_legal;
            end
            if (!idle_prev && prev == s + len)
                s = -1;
            if (idle_prev && start) begin
                s = prev;
                m_op = opcode;
                m_rt = rt;
                m_legal = m_legal_of(opcode, rt);
                len = m_legal ? 4 : 2;
                m_tk = 0;
            end
        end
    end

    always @(negedge clk) begin
        int         d;
        logic       e_a, e_load, e_pw, e_done, e_busy;
        logic [1:0] e_b;
        logic [2:0] e_op;
        if (!reset) begin
            e_a = 0; e_load = 0; e_pw = 0; e_done = 0; e_busy = 0;
            e_b = 0; e_op = 0;
            d = (s < 0) ? 0 : cyc - s;
            if (s >= 0) e_busy = 1;
            if (s >= 0 && m_legal) begin
                case (d)
                    1: begin e_b = 2'b11; e_op = 3'b001; e_load = 1; end
                    2: begin
                        e_a = 1; e_op = 3'b010;
                        e_b = (m_op == 6'd4 || m_op == 6'd5) ? 2'b00 : 2'b10;
                    end
                    3: e_pw = m_tk;
                    4: e_done = 1;
                    default: ;
                endcase
            end
            if (s >= 0 && !m_legal && d == 2) e_done = 1;
            chk("m_alu_src_a", alu_src_a, e_a);
            chk("m_alu_src_b", alu_src_b, e_b);
            chk("m_alu_op", alu_op, e_op);
            chk("m_aluout_load", aluout_load, e_load);
            chk("m_pc_src", pc_src_aluout, e_pw);
            chk("m_pc_write", pc_write, e_pw);
            chk("m_busy", busy, e_busy);
            chk("m_done", done, e_done);
            chk("m_taken", taken, m_taken);
            chk("m_illegal", illegal, m_ill);
            chk("m_cnt", taken_cnt, m_cnt);
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic run_br(input string tag, input logic [5:0] op, input logic [4:0] r,
                          input logic ig, input logic ma, input logic me,
                          input logic clr_res, input logic poke, input logic leg,
                          input logic tk, input logic [1:0] eb, input int ecnt);
        wait_idle();
        opcode = op; rt = r; igual = ig; maior = ma; menor = me; start = 1;
        @(posedge clk); #1;
        start = poke;
        if (leg) begin
            chk({tag, "_tgt_a"}, alu_src_a, 0);
            chk({tag, "_tgt_b"}, alu_src_b, 2'b11);
            chk({tag, "_tgt_op"}, alu_op, 3'b001);
            chk({tag, "_tgt_load"}, aluout_load, 1);
            @(posedge clk); #1;
            start = 0;
            chk({tag, "_cmp_a"}, alu_src_a, 1);
            chk({tag, "_cmp_b"}, alu_src_b, eb);
            chk({tag, "_cmp_op"}, alu_op, 3'b010);
            @(posedge clk); #1;
            clr_cnt = clr_res;
            chk({tag, "_res_pcw"}, pc_write, tk);
            @(posedge clk); #1;
            clr_cnt = 0;
            chk({tag, "_fin_done"}, done, 1);
            chk({tag, "_fin_taken"}, taken, tk);
            chk({tag, "_fin_ill"}, illegal, 0);
            chk({tag, "_fin_cnt"}, taken_cnt, ecnt);
        end else begin
            chk({tag, "_ill_busy"}, busy, 1);
            chk({tag, "_ill_op"}, alu_op, 0);
            chk({tag, "_ill_load"}, aluout_load, 0);
            chk({tag, "_ill_pcw"}, pc_write, 0);
            @(posedge clk); #1;
            start = 0;
            chk({tag, "_ill_done"}, done, 1);
            chk({tag, "_ill_flag"}, illegal, 1);
            chk({tag, "_ill_taken"}, taken, 0);
            chk({tag, "_ill_cnt"}, taken_cnt, ecnt);
        end
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pcw", pc_write, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_cnt", taken_cnt, 0);
        reset = 0;

        // Async reset during COMPARE of a taken bgtz aborts the branch.
        wait_idle();
        opcode = 6'd7; rt = 0; maior = 1; igual = 0; menor = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #3;
        reset = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_op", alu_op, 0);
        chk("abort_a", alu_src_a, 0);
        chk("abort_pcw", pc_write, 0);
        chk("abort_cnt", taken_cnt, 0);
        @(posedge clk); #1;
        reset = 0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("abort_no_pcw", pc_write, 0);
            chk("abort_no_done", done, 0);
        end
        chk("abort_cnt_after", taken_cnt, 0);
        maior = 0;

        run_br("beq_t",  6'd4, 5'd0, 1, 0, 0, 0, 0, 1, 1, 2'b00, 1);
        run_br("bne_n",  6'd5, 5'd0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 1);
        run_br("bltz_t", 6'd1, 5'd0, 0, 0, 1, 0, 0, 1, 1, 2'b10, 2);
        run_br("bgez_n", 6'd1, 5'd1, 0, 0, 1, 0, 0, 1, 0, 2'b10, 2);
        run_br("rt2",    6'd1, 5'd2, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2);
        run_br("op8",    6'd8, 5'd0, 1, 1, 1, 0, 1, 0, 0, 2'b00, 2);

        wait_idle();
        clr_cnt = 1;
        @(posedge clk); #1;
        clr_cnt = 0;
        chk("clr_alone", taken_cnt, 0);

        run_br("blez1", 6'd6, 5'd0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 1);
        run_br("blez2", 6'd6, 5'd0, 0, 0, 0, 0, 1, 1, 1, 2'b10, 2);
        run_br("blez3", 6'd6, 5'd0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 3);
        run_br("blez4", 6'd6, 5'd0, 0, 0, 0, 0, 0, 1, 1, 2'b10, 0);
        run_br("clr_inc", 6'd4, 5'd0, 1, 0, 0, 1, 0, 1, 1, 2'b00, 0);
        run_br("bgez_t", 6'd1, 5'd1, 0, 0, 0, 0, 0, 1, 1, 2'b10, 1);
        run_br("bltz_n", 6'd1, 5'd0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 1);
        run_br("blez_n", 6'd6, 5'd0, 0, 1, 0, 0, 0, 1, 0, 2'b10, 1);
        run_br("bgtz_t", 6'd7, 5'd0, 0, 1, 0, 0, 0, 1, 1, 2'b10, 2);
        run_br("bne_t",  6'd5, 5'd0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 3);

        repeat (4000) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0: opcode = 6'd1;
                1: opcode = 6'd4;
                2: opcode = 6'd5;
                3: opcode = 6'd6;
                4: opcode = 6'd7;
                default: opcode = 6'($urandom_range(0, 63));
            endcase
            rt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(0, 1));
            igual = 1'($urandom_range(0, 1));
            maior = 1'($urandom_range(0, 1));
            menor = 1'($urandom_range(0, 1));
            clr_cnt = ($urandom_range(0, 19) == 0);
        end
        start = 0;
        clr_cnt = 0;
        repeat (8) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
